lc3_control: RTL and testbench

- Multi-cycle control FSM that sequences the LC-3 datapath. It drives every load and write-enable strobe (ldPC, ldMAR, ldMDR, ldIR, flagWE, regWE, memWE) and every mux select.
- Sits beside the datapath inside lc3. It consumes IR, the NZP flags and a memory-ready handshake.
- Implements BR, ADD, LD, ST, JSR/JSRR, AND, NOT and JMP. All other opcodes execute as NOPs.

---
 rtl/lc3_control.sv | 212 +++++++++++++++++++++
 tb/tb_lc3_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control.sv
// Multi-cycle control FSM for the LC-3 datapath: fetch, decode and execute
// sequencing, with bounded memory wait states and a sticky timeout flag.
module lc3_control #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic        mem_rdy,
    output logic        ldPC,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldIR,
    output logic        flagWE,
    output logic        regWE,
    output logic        memWE,
    output logic [1:0]  pcSel,
    output logic        addr1Sel,
    output logic [1:0]  addr2Sel,
    output logic [2:0]  gateSel,
    output logic        mdrSel,
    output logic [1:0]  aluOp,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic        err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0, F1 = 4'd1, F2 = 4'd2, F3 = 4'd3,
        DEC  = 4'd4, ALU = 4'd5, BR = 4'd6, JMP = 4'd7,
        JSR1 = 4'd8, JSR2 = 4'd9, LD1 = 4'd10, LD2 = 4'd11,
        LD3  = 4'd12, ST1 = 4'd13, ST2 = 4'd14, ST3 = 4'd15
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic [2:0] GATE_PC    = 3'b001;
    localparam logic [2:0] GATE_ALU   = 3'b010;
    localparam logic [2:0] GATE_MDR   = 3'b011;
    localparam logic [2:0] GATE_MARMX = 3'b100;

    localparam logic [1:0] PC_ADDER   = 2'b01;
    localparam logic [1:0] OFF_SEXT9  = 2'b01;
    localparam logic [1:0] OFF_SEXT11 = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_NOT   = 2'b10;
    localparam logic [1:0] ALU_PASSA = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;
    logic             in_wait;
    logic             timeout_hit;
    logic             br_taken;
    logic [3:0]       opcode;
    logic             unused_ir_bits;

    assign opcode         = ir[15:12];
    assign unused_ir_bits = ^ir[5:0];
    assign br_taken       = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    assign in_wait        = (state_reg == F2) || (state_reg == LD2) || (state_reg == ST3);
    assign timeout_hit    = in_wait && !mem_rdy && (cnt_reg == CNT_LAST);

    assign state = state_reg;
    assign err   = err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            // Counter only runs inside a wait state, so every entry starts from zero.
            cnt_reg <= (in_wait && !mem_rdy) ? cnt_reg + 1'b1 : '0;
            if (timeout_hit) begin
                err_reg   <= 1'b1;
                state_reg <= F1;
            end else begin
                case (state_reg)
                    IDLE: state_reg <= F1;
                    F1:   state_reg <= F2;
                    F2:   if (mem_rdy) state_reg <= F3;
                    F3:   state_reg <= DEC;
                    DEC: begin
                        case (opcode)
                            OP_ADD, OP_AND, OP_NOT: state_reg <= ALU;
                            OP_BR:  state_reg <= br_taken ? BR : F1;
                            OP_JMP: state_reg <= JMP;
                            OP_JSR: state_reg <= JSR1;
                            OP_LD:  state_reg <= LD1;
                            OP_ST:  state_reg <= ST1;
                            default: state_reg <= F1;
                        endcase
                    end
                    JSR1: state_reg <= JSR2;
                    LD1:  state_reg <= LD2;
                    LD2:  if (mem_rdy) state_reg <= LD3;
                    ST1:  state_reg <= ST2;
                    ST2:  state_reg <= ST3;
                    ST3:  if (mem_rdy) state_reg <= F1;
                    default: state_reg <= F1;
                endcase
            end
        end
    end

    // Outputs decode the registered state, so an async reset drops them at once.
    always_comb begin
        ldPC     = 1'b0;
        ldMAR    = 1'b0;
        ldMDR    = 1'b0;
        ldIR     = 1'b0;
        flagWE   = 1'b0;
        regWE    = 1'b0;
        memWE    = 1'b0;
        pcSel    = 2'b00;
        addr1Sel = 1'b0;
        addr2Sel = 2'b00;
        gateSel  = 3'b000;
        mdrSel   = 1'b0;
        aluOp    = ALU_ADD;
        dr       = 3'd0;
        sr1      = 3'd0;
        case (state_reg)
            F1: begin
                gateSel = GATE_PC;
                ldMAR   = 1'b1;
                ldPC    = 1'b1;
            end
            F2, LD2: ldMDR = mem_rdy;
            F3: begin
                gateSel = GATE_MDR;
                ldIR    = 1'b1;
            end
            ALU: begin
                gateSel = GATE_ALU;
                regWE   = 1'b1;
                flagWE  = 1'b1;
                dr      = ir[11:9];
                sr1     = ir[8:6];
                case (opcode)
                    OP_AND:  aluOp = ALU_AND;
                    OP_NOT:  aluOp = ALU_NOT;
                    default: aluOp = ALU_ADD;
                endcase
            end
            BR: begin
                ldPC     = 1'b1;
                pcSel    = PC_ADDER;
                addr2Sel = OFF_SEXT9;
            end
            JMP: begin
                ldPC     = 1'b1;
                pcSel    = PC_ADDER;
                addr1Sel = 1'b1;
                sr1      = ir[8:6];
            end
            JSR1: begin
                gateSel = GATE_PC;
                regWE   = 1'b1;
                dr      = 3'd7;
            end
            JSR2: begin
                ldPC  = 1'b1;
                pcSel = PC_ADDER;
                if (ir[11]) begin
                    addr2Sel = OFF_SEXT11;
                end else begin
                    addr1Sel = 1'b1;
                    sr1      = ir[8:6];
                end
            end
            LD1, ST1: begin
                gateSel  = GATE_MARMX;
                addr2Sel = OFF_SEXT9;
                ldMAR    = 1'b1;
            end
            LD3: begin
                gateSel = GATE_MDR;
                regWE   = 1'b1;
                flagWE  = 1'b1;
                dr      = ir[11:9];
            end
            ST2: begin
                sr1     = ir[11:9];
                aluOp   = ALU_PASSA;
                gateSel = GATE_ALU;
                mdrSel  = 1'b1;
                ldMDR   = 1'b1;
            end
            ST3: memWE = !timeout_hit;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control.sv
// Scoreboard bench for lc3_control: stimulus queues hand-computed per-cycle
// output vectors, a negedge monitor pops and compares them.
module tb_lc3_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        n, z, p, mem_rdy;
    logic        ldPC, ldMAR, ldMDR, ldIR, flagWE, regWE, memWE;
    logic [1:0]  pcSel, addr2Sel, aluOp;
    logic        addr1Sel, mdrSel, err;
    logic [2:0]  gateSel, dr, sr1;
    logic [3:0]  state;

    always #5 clk = ~clk;

    lc3_control #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p), .mem_rdy(mem_rdy),
        .ldPC(ldPC), .ldMAR(ldMAR), .ldMDR(ldMDR), .ldIR(ldIR),
        .flagWE(flagWE), .regWE(regWE), .memWE(memWE),
        .pcSel(pcSel), .addr1Sel(addr1Sel), .addr2Sel(addr2Sel),
        .gateSel(gateSel), .mdrSel(mdrSel), .aluOp(aluOp),
        .dr(dr), .sr1(sr1), .err(err), .state(state)
    );

    // stb = {ldPC, ldMAR, ldMDR, ldIR, flagWE, regWE, memWE}
    typedef struct packed {
        logic [3:0] st;
        logic [6:0] stb;
        logic [1:0] pcs;
        logic       a1;
        logic [1:0] a2;
        logic [2:0] gate;
        logic       mdr;
        logic [1:0] alu;
        logic [2:0] drv;
        logic [2:0] srv;
        logic       er;
    } vec_t;

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  exp_err = 1'b0;

    function automatic vec_t mk(input logic [3:0] st, input logic [6:0] stb,
                                input logic [1:0] pcs, input logic a1,
                                input logic [1:0] a2, input logic [2:0] gate,
                                input logic mdr, input logic [1:0] alu,
                                input logic [2:0] drv, input logic [2:0] srv);
        vec_t v;
        v.st = st; v.stb = stb; v.pcs = pcs; v.a1 = a1; v.a2 = a2;
        v.gate = gate; v.mdr = mdr; v.alu = alu; v.drv = drv; v.srv = srv;
        v.er = exp_err;
        return v;
    endfunction

    task automatic cyc(input logic rdy, input vec_t v, input string tag);
        mem_rdy = rdy;
        exp_q.push_back(v);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits);
        cyc(1'b1, mk(4'd1, 7'b1100000, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 3'd0, 3'd0), "F1");
        for (int i = 0; i < waits; i++)
            cyc(1'b0, mk(4'd2, 7'b0000000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "F2 wait");
        cyc(1'b1, mk(4'd2, 7'b0010000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "F2 ready");
        cyc(1'b1, mk(4'd3, 7'b0001000, 2'b00, 1'b0, 2'b00, 3'b011, 1'b0, 2'b00, 3'd0, 3'd0), "F3");
        cyc(1'b1, mk(4'd4, 7'b0000000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "DEC");
    endtask

    task automatic start(input logic [15:0] irv, input string name);
        ir = irv;
        $display("txn %s ir=%h nzp=%b%b%b err_exp=%0b", name, irv, n, z, p, exp_err);
    endtask

    // Monitor: compares every sampled cycle against the head of the scoreboard.
    initial begin
        vec_t  e;
        vec_t  act;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = {state, ldPC, ldMAR, ldMDR, ldIR, flagWE, regWE, memWE,
                       pcSel, addr1Sel, addr2Sel, gateSel, mdrSel, aluOp, dr, sr1, err};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: actual=%h required=%h", t, act, e);
                end
            end
        end
    end

    initial begin
        vec_t zero_v;
        rst = 1'b1; ir = 16'h0000; n = 1'b0; z = 1'b0; p = 1'b0; mem_rdy = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        zero_v = mk(4'd0, 7'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0);
        $display("txn reset held 3 cycles");
        repeat (3) cyc(1'b1, zero_v, "reset held");
        rst = 1'b1;
        cyc(1'b1, zero_v, "idle after reset");

        start(16'h1283, "ADD R1,R2,R3");
        fetch(0);
        cyc(1'b1, mk(4'd5, 7'b0000110, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 2'b00, 3'd1, 3'd2), "ADD exec");

        start(16'h5283, "AND R1,R2,R3");
        fetch(2);
        cyc(1'b1, mk(4'd5, 7'b0000110, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 2'b01, 3'd1, 3'd2), "AND exec");

        start(16'h9A7F, "NOT R5,R1");
        fetch(0);
        cyc(1'b1, mk(4'd5, 7'b0000110, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 2'b10, 3'd5, 3'd1), "NOT exec");

        n = 1'b0; z = 1'b1; p = 1'b0;
        start(16'h0A05, "BRnp not taken");
        fetch(0);

        n = 1'b1; z = 1'b0; p = 1'b0;
        start(16'h0A05, "BRnp taken");
        fetch(0);
        cyc(1'b1, mk(4'd6, 7'b1000000, 2'b01, 1'b0, 2'b01, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "BR exec");

        start(16'hC1C0, "JMP R7");
        fetch(0);
        cyc(1'b1, mk(4'd7, 7'b1000000, 2'b01, 1'b1, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd7), "JMP exec");

        start(16'h4803, "JSR");
        fetch(0);
        cyc(1'b1, mk(4'd8, 7'b0000010, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 3'd7, 3'd0), "JSR1");
        cyc(1'b1, mk(4'd9, 7'b1000000, 2'b01, 1'b0, 2'b10, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "JSR2 offset");

        start(16'h4080, "JSRR R2");
        fetch(0);
        cyc(1'b1, mk(4'd8, 7'b0000010, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 3'd7, 3'd0), "JSRR JSR1");
        cyc(1'b1, mk(4'd9, 7'b1000000, 2'b01, 1'b1, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd2), "JSRR JSR2");

        start(16'h2A05, "LD R5");
        fetch(0);
        cyc(1'b1, mk(4'd10, 7'b0100000, 2'b00, 1'b0, 2'b01, 3'b100, 1'b0, 2'b00, 3'd0, 3'd0), "LD1");
        cyc(1'b0, mk(4'd11, 7'b0000000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "LD2 wait");
        cyc(1'b1, mk(4'd11, 7'b0010000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "LD2 ready");
        cyc(1'b1, mk(4'd12, 7'b0000110, 2'b00, 1'b0, 2'b00, 3'b011, 1'b0, 2'b00, 3'd5, 3'd0), "LD3");

        start(16'h3E10, "ST R7");
        fetch(0);
        cyc(1'b1, mk(4'd13, 7'b0100000, 2'b00, 1'b0, 2'b01, 3'b100, 1'b0, 2'b00, 3'd0, 3'd0), "ST1");
        cyc(1'b1, mk(4'd14, 7'b0010000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1, 2'b11, 3'd0, 3'd7), "ST2");
        repeat (3)
            cyc(1'b0, mk(4'd15, 7'b0000001, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "ST3 wait");
        cyc(1'b1, mk(4'd15, 7'b0000001, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "ST3 ready");

        start(16'hD000, "reserved opcode NOP");
        fetch(0);

        start(16'h1283, "fetch timeout");
        cyc(1'b1, mk(4'd1, 7'b1100000, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 3'd0, 3'd0), "F1");
        repeat (15)
            cyc(1'b0, mk(4'd2, 7'b0000000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "F2 timeout wait");
        cyc(1'b0, mk(4'd2, 7'b0000000, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0), "F2 timeout abort");
        exp_err = 1'b1;

        start(16'h1283, "ADD after timeout");
        fetch(0);
        cyc(1'b1, mk(4'd5, 7'b0000110, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 2'b00, 3'd1, 3'd2), "ADD exec err set");

        start(16'h1283, "ADD aborted by reset");
        fetch(0);
        rst = 1'b0;
        exp_err = 1'b0;
        zero_v = mk(4'd0, 7'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 2'b00, 3'd0, 3'd0);
        cyc(1'b1, zero_v, "async reset mid-ALU");
        cyc(1'b1, zero_v, "reset held again");
        rst = 1'b1;
        cyc(1'b1, zero_v, "idle after second reset");

        start(16'h1283, "ADD after reset");
        fetch(0);
        cyc(1'b1, mk(4'd5, 7'b0000110, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 2'b00, 3'd1, 3'd2), "ADD exec final");
        cyc(1'b1, mk(4'd1, 7'b1100000, 2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 2'b00, 3'd0, 3'd0), "F1 final");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
